// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
// Pops one FIFO word per frame and serialises it as 8N1 UART, LSB first; read strobe one cycle after empty falls.
// Frame = FETCH + (DATA_WIDTH+2)*CLKS_PER_BIT cycles; the FIFO is the only backpressure, words wait there until popped.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_re,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

    state_t                  state;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign fifo_re = (state == FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state   <= FETCH;
                        tx_busy <= 1'b1;
                    end
                end
                FETCH: begin
                    shift_reg <= fifo_rdata;
                    baud_cnt  <= '0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                        // tx is registered, so present the next bit one shift ahead
                        if (bit_cnt == BIT_LAST) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_PRE) tx_done <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            state <= FETCH;
                        end else begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the team's FIFO control unit plus memory.
- Watches the FIFO `empty` flag and pops one word at a time with a single-cycle read strobe.
- Latches the popped word and serialises it as an 8N1 UART frame on `tx`.
- Sits between the FIFO and the board's serial TX pin; it drains everything the write side pushes.

Parameters:
- DATA_WIDTH, 8, width of a FIFO word and number of data bits per frame.
- CLKS_PER_BIT, 10416, clock cycles per UART bit (100 MHz / 9600 baud). Must be >= 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag, registered on the FIFO side.
- fifo_rdata  input  DATA_WIDTH  word at the FIFO read pointer; valid whenever fifo_empty=0.
- fifo_re  output  1  read strobe; the FIFO advances rptr on the edge where it is sampled high.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high in FETCH, START, DATA and STOP.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Clock and reset: single clock `clk`; `rst` is asynchronous and active-high.
- Reset values:
  - state=IDLE, tx=1, fifo_re=0, tx_busy=0, tx_done=0.
  - baud_cnt=0, bit_cnt=0, shift register=0.
- Output registering:
  - tx is driven from a register (glitch-free).
  - fifo_re is decoded from state==FETCH only.
- States:
  - IDLE: tx=1. If fifo_empty=0, go to FETCH next cycle.
  - FETCH: exactly 1 cycle. fifo_re=1. shift_reg<=fifo_rdata at the end of the cycle. Go to START; baud_cnt<=0.
  - START: tx=0 for CLKS_PER_BIT cycles. Then go to DATA with bit_cnt=0.
  - DATA: tx=shift_reg[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. At the end of a bit, shift right and bit_cnt+1. After bit DATA_WIDTH-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. In the last cycle tx_done=1. Next state is FETCH if fifo_empty=0, else IDLE.
- Counters:
  - baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary. Width is $clog2(CLKS_PER_BIT).
  - bit_cnt width is $clog2(DATA_WIDTH)+1.
- Frame length: 1+DATA_WIDTH+1 bits, i.e. (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus the 1 FETCH cycle.
- Back-to-back words: the inter-frame gap is exactly 1 clock of tx=1 (the FETCH cycle). The block never returns through IDLE while the FIFO is non-empty.
- Read safety:
  - fifo_re is asserted only in FETCH.
  - FETCH is entered only when fifo_empty was sampled 0.
  - So the block never pops an empty FIFO, and issues exactly one pop per frame.
- fifo_rdata is sampled only in FETCH. Changes at other times have no effect on the frame in flight.
- Writes while empty: the write side may push at any time. The block reacts to fifo_empty falling within 1 cycle from IDLE.
- Full FIFO: no special handling. A pop in FETCH frees one slot.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronous); state goes to IDLE and counters clear.
  - The word already popped is discarded, not re-read.
- fifo_empty glitching high during a frame is ignored. It is sampled only in IDLE and in the last STOP cycle.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8):
- Reset idle: hold rst, then release with fifo_empty=1 for 100 cycles -> tx=1, fifo_re=0, tx_busy=0 throughout.
- Single byte: fifo_empty falls with rdata=8'hA5 -> 1 fifo_re pulse, then tx sequence 0,1,0,1,0,0,1,0,1,1 (each bit 4 cycles) -> tx_done pulse after 40 cycles of START..STOP, then IDLE.
- Back-to-back: FIFO holds 8'h00 then 8'hFF -> 2 fifo_re pulses exactly 41 cycles apart; tx=1 for only 1 cycle between the stop bit and the second start bit.
- Empty guard: FIFO drains after 3 words -> exactly 3 fifo_re pulses and 3 tx_done pulses; no fifo_re ever while fifo_empty=1.
- Reset mid-frame: assert rst during data bit 3 of 8'h3C -> tx=1 in the same cycle, tx_busy=0. After release with fifo_empty=0, the next frame carries the next FIFO word, not 8'h3C.
- Late data change: alter fifo_rdata during START/DATA -> the transmitted byte equals the value latched in FETCH.
